// File: rtl/johnson_sequence_controller_pkg.sv
// Shared types and helpers for the Johnson sequence controller: FSM state
// encoding, counter geometry, and the phase <-> Johnson-code mapping.
package johnson_sequence_controller_pkg;

    localparam int JC_WIDTH  = 8;
    localparam int JC_PHASES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } jsc_state_e;

    // Phases 0..8 fill ones from the LSB; 9..15 keep (16-p) ones in the MSBs.
    function automatic logic [JC_WIDTH-1:0] jc_encode(input logic [3:0] p);
        logic [JC_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < JC_WIDTH; i++) begin
            if (p <= 4'd8) v[i] = (i < int'(p));
            else           v[i] = (i >= int'(p) - 8);
        end
        return v;
    endfunction

    function automatic logic [3:0] jc_decode(input logic [JC_WIDTH-1:0] v);
        logic [4:0] pc;
        logic [4:0] idx;
        pc = '0;
        for (int i = 0; i < JC_WIDTH; i++) pc = pc + {4'd0, v[i]};
        idx = v[JC_WIDTH-1] ? (5'd16 - pc) : pc;
        return idx[3:0];
    endfunction

endpackage

// File: rtl/johnson_sequence_controller_ctr.sv
// 8-bit Johnson counter register with a parallel load that overrides stepping.
module johnson_counter_ctl
    import johnson_sequence_controller_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic [JC_WIDTH-1:0] load_val,
    output logic [JC_WIDTH-1:0] out
);

    logic [JC_WIDTH-1:0] out_q, out_d;

    always_comb begin
        out_d = out_q;
        if (load)    out_d = load_val;
        else if (en) out_d = {out_q[JC_WIDTH-2:0], ~out_q[JC_WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) out_q <= '0;
        else        out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: rtl/johnson_sequence_controller.sv
// Run controller: loads a start phase, steps the Johnson counter a programmed
// number of times with pause/abort, and pulses done on completion.
module johnson_sequence_controller
    import johnson_sequence_controller_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          start_phase,
    input  logic [4:0]          step_count,
    input  logic                pause,
    input  logic                abort,
    output logic [JC_WIDTH-1:0] out,
    output logic [3:0]          phase,
    output logic                busy,
    output logic                done
);

    jsc_state_e state_q, state_d;
    logic [4:0] rem_q, rem_d;
    logic       ctr_en, ctr_load;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        ctr_en   = 1'b0;
        ctr_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ctr_load = 1'b1;
                    rem_d    = step_count;
                    state_d  = (step_count != 5'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else begin
                    ctr_en = 1'b1;
                    rem_d  = rem_q - 5'd1;
                    // Leaving at 1 keeps the down-counter from ever wrapping.
                    if (rem_q == 5'd1) state_d = ST_DONE;
                end
            end
            ST_PAUSED: begin
                if (abort)       state_d = ST_IDLE;
                else if (!pause) state_d = ST_RUN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    johnson_counter_ctl u_ctr (
        .clk      (clk),
        .reset    (reset),
        .en       (ctr_en),
        .load     (ctr_load),
        .load_val (jc_encode(start_phase)),
        .out      (out)
    );

    assign phase = jc_decode(out);
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_johnson_sequence_controller.sv
// Directed bench for johnson_sequence_controller with hand-computed vectors
// and a per-cycle monitor on phase decoding and done pulse width.
module tb_johnson_sequence_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] start_phase;
    logic [4:0] step_count;
    logic       pause;
    logic       abort;
    logic [7:0] out;
    logic [3:0] phase;
    logic       busy;
    logic       done;

    int  n_chk = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    johnson_sequence_controller dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_phase (start_phase),
        .step_count  (step_count),
        .pause       (pause),
        .abort       (abort),
        .out         (out),
        .phase       (phase),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_st(input string tag, input logic [7:0] o, input logic b, input logic d);
        chk({tag, ".out"},  {24'd0, out},  {24'd0, o});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Index of v in the Johnson sequence, walked from 00000000.
    function automatic int ref_phase(input logic [7:0] v);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (s === v) return i;
            s = {s[6:0], ~s[7]};
        end
        return 99;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon.phase", {28'd0, phase}, ref_phase(out));
            chk("mon.done_1cyc", {31'd0, done & prev_done}, 32'd0);
            prev_done <= done;
        end
    end

    logic [7:0] exp_a [5];
    logic [7:0] exp_b [5];
    logic [7:0] exp_c [6];
    logic [7:0] exp_d [6];

    initial begin
        exp_a = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
        exp_b = '{8'hC0, 8'h80, 8'h00, 8'h01, 8'h03};
        exp_c = '{8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        exp_d = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0};

        reset = 1'b0; start = 1'b0; start_phase = '0; step_count = '0;
        pause = 1'b0; abort = 1'b0;
        step(); step();
        exp_st("rst", 8'h00, 1'b0, 1'b0);
        chk("rst.phase", {28'd0, phase}, 32'd0);
        mon_en = 1'b1;
        reset = 1'b1;
        step();

        // Phase 0, five steps
        start = 1'b1; start_phase = 4'd0; step_count = 5'd5;
        step(); start = 1'b0;
        exp_st("a.load", 8'h00, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("a.out", {24'd0, out}, {24'd0, exp_a[n]});
            chk("a.phase", {28'd0, phase}, n + 1);
            chk("a.done", {31'd0, done}, (n == 4) ? 32'd1 : 32'd0);
        end
        chk("a.busy_end", {31'd0, busy}, 32'd0);
        step();
        exp_st("a.idle", 8'h1F, 1'b0, 1'b0);

        // Wrap-around from phase 14
        start = 1'b1; start_phase = 4'd14; step_count = 5'd4;
        step(); start = 1'b0;
        chk("b.load", {24'd0, out}, {24'd0, exp_b[0]});
        chk("b.phase0", {28'd0, phase}, 32'd14);
        for (int n = 1; n < 5; n++) begin
            step();
            chk("b.out", {24'd0, out}, {24'd0, exp_b[n]});
            chk("b.phase", {28'd0, phase}, (14 + n) % 16);
        end
        chk("b.done", {31'd0, done}, 32'd1);
        step();

        // Eight steps with a three-cycle pause after the second shift
        start = 1'b1; start_phase = 4'd0; step_count = 5'd8;
        step(); start = 1'b0;
        step(); exp_st("c.s1", 8'h01, 1'b1, 1'b0);
        step(); exp_st("c.s2", 8'h03, 1'b1, 1'b0);
        pause = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(); exp_st("c.pause", 8'h03, 1'b1, 1'b0);
        end
        pause = 1'b0;
        step(); exp_st("c.resume", 8'h03, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            step();
            exp_st("c.run", exp_c[n], (n == 5) ? 1'b0 : 1'b1, (n == 5) ? 1'b1 : 1'b0);
        end
        step(); exp_st("c.idle", 8'hFF, 1'b0, 1'b0);

        // Abort after third shift, then immediate restart
        start = 1'b1; start_phase = 4'd3; step_count = 5'd10;
        step(); start = 1'b0;
        exp_st("d.load", 8'h07, 1'b1, 1'b0);
        step(); step(); step();
        exp_st("d.s3", 8'h3F, 1'b1, 1'b0);
        abort = 1'b1;
        step(); abort = 1'b0;
        exp_st("d.abort", 8'h3F, 1'b0, 1'b0);
        start = 1'b1; start_phase = 4'd0; step_count = 5'd1;
        step(); start = 1'b0;
        exp_st("d.restart", 8'h00, 1'b1, 1'b0);
        step(); exp_st("d.one", 8'h01, 1'b0, 1'b1);
        step();

        // Zero-length run
        start = 1'b1; start_phase = 4'd5; step_count = 5'd0;
        step(); start = 1'b0;
        exp_st("e.zero", 8'h1F, 1'b0, 1'b1);
        step(); exp_st("e.idle", 8'h1F, 1'b0, 1'b0);

        // Start held high during a six-step run must be ignored
        start = 1'b1; start_phase = 4'd8; step_count = 5'd6;
        step();
        exp_st("f.load", 8'hFF, 1'b1, 1'b0);
        start_phase = 4'd0; step_count = 5'd2;
        for (int n = 0; n < 6; n++) begin
            step();
            if (n == 1) start = 1'b0;
            exp_st("f.run", exp_d[n], (n == 5) ? 1'b0 : 1'b1, (n == 5) ? 1'b1 : 1'b0);
        end
        step(); exp_st("f.idle", 8'hC0, 1'b0, 1'b0);

        // Reset mid-RUN with start/abort/pause also high
        start = 1'b1; start_phase = 4'd0; step_count = 5'd10;
        step(); start = 1'b0;
        step(); step(); step();
        exp_st("g.s3", 8'h07, 1'b1, 1'b0);
        reset = 1'b0; start = 1'b1; abort = 1'b1; pause = 1'b1;
        step();
        exp_st("g.rst", 8'h00, 1'b0, 1'b0);
        reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        step(); exp_st("g.after", 8'h00, 1'b0, 1'b0);

        // Reset while PAUSED
        start = 1'b1; start_phase = 4'd4; step_count = 5'd10;
        step(); start = 1'b0;
        step(); exp_st("h.s1", 8'h1F, 1'b1, 1'b0);
        pause = 1'b1;
        step(); exp_st("h.paused", 8'h1F, 1'b1, 1'b0);
        reset = 1'b0;
        step(); exp_st("h.rst", 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        step(); exp_st("h.after", 8'h00, 1'b0, 1'b0);
        pause = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/johnson_sequence_controller.md
JOHNSON_SEQUENCE_CONTROLLER -- requirements
Module: johnson_sequence_controller

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge.
REQ-002 reset  input  1  synchronous active-low reset; sampled on posedge clk; reset=0 initializes the block.
REQ-003 start  input  1  command pulse; begin a run of step_count shifts.
REQ-004 start_phase  input  4  phase (0..15) loaded into the counter when start is accepted.
REQ-005 step_count  input  5  number of shifts in the run (0..31); sampled only when start is accepted.
REQ-006 pause  input  1  level; freezes an active run while high.
REQ-007 abort  input  1  pulse; terminates an active run without done.
REQ-008 out  output  8  current Johnson counter state.
REQ-009 phase  output  4  decoded sequence index of out.
REQ-010 busy  output  1  high in RUN and PAUSED.
REQ-011 done  output  1  one-cycle pulse on run completion.

Function
REQ-012 The Johnson shift SHALL be out <= {out[6:0], ~out[7]}, giving the 16-state cycle 00000000, 00000001, ..., 11111111, 11111110, ..., 10000000, then back to 00000000.
REQ-013 phase SHALL be combinational from out: popcount(out) when out[7]=0, otherwise 16-popcount(out), reduced mod 16 (so 11111111 gives 8, 10000000 gives 15).
REQ-014 Encoding of start_phase p SHALL be: p<=8 gives p ones in the LSBs; p>8 gives (16-p) ones in the MSBs; the encoding is the exact inverse of REQ-013.
REQ-015 The FSM SHALL have states IDLE, RUN, PAUSED, DONE; busy=1 exactly in RUN/PAUSED; done=1 exactly in DONE.
REQ-016 IDLE: out holds. When start=1:
- out <= encode(start_phase)
- remaining <= step_count
- next state RUN if step_count!=0, else DONE with out loaded and no shift.
REQ-017 RUN, checked in priority order abort > pause > advance:
- abort=1: go to IDLE; out holds; no done.
- pause=1: go to PAUSED; out holds.
- otherwise: shift out once and decrement remaining; when remaining==1 before the decrement, go to DONE.
REQ-018 PAUSED:
- abort=1: go to IDLE.
- pause=0: go to RUN with no shift on that edge; the first shift happens on the following edge.
- otherwise: hold.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE; out holds.
REQ-020 start SHALL be ignored in RUN, PAUSED and DONE; abort and pause SHALL be ignored in IDLE and DONE.
REQ-021 Latency: with start accepted at edge k and pause low, the n-th shift occurs at edge k+n, and done is high during the cycle after edge k+N (N = step_count).
REQ-022 Wrap-around: 10000000 SHALL shift to 00000000 and the run continues; a 16-step run returns out to its start value.
REQ-023 remaining SHALL be a 5-bit register; it never underflows, because the transition to DONE occurs at remaining==1.

Reset
REQ-024 When reset=0 at a posedge, the block SHALL set state=IDLE, out=00000000, remaining=0, busy=0, done=0, regardless of current state (including mid-run or PAUSED).
REQ-025 Reset SHALL take priority over start, abort and pause sampled on the same edge.
REQ-026 Before the first reset edge, outputs are don't-care; the bench SHALL drive reset=0 for at least one edge.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state enum (2 bits)
- constant JC_WIDTH=8
- constant JC_PHASES=16
- phase encode/decode functions.
REQ-028 The counter SHALL be one sub-module, johnson_counter_ctl, with ports clk, reset, en, load, load_val[7:0] and out[7:0]; the controller drives en and load; load has priority over en.
REQ-029 All registers SHALL be in the same clock domain; there SHALL be no latches, and no asynchronous reset paths.

Verification
REQ-030 Reset then start with start_phase=0, step_count=5 -> out steps 00000001, 00000011, 00000111, 00001111, 00011111; phase 1..5; done high one cycle after the 5th shift; busy low afterwards.
REQ-031 Start with start_phase=14, step_count=4 -> out 11000000 (load), then 10000000, 00000000, 00000001, 00000011; phase sequence 14, 15, 0, 1, 2 (wrap-around).
REQ-032 Start with step_count=8, pause high for 3 cycles after the 2nd shift -> out frozen for 3+1 cycles; exactly 8 shifts total; done is delayed by 4 cycles relative to the unpaused run.
REQ-033 Start with step_count=10, abort after the 3rd shift -> out holds at phase start+3; busy falls; done is never asserted; a new start is accepted the next cycle.
REQ-034 Start with step_count=0 -> out loaded, no shift, done pulses one cycle later; start asserted again while busy in a 6-step run -> ignored, run completes as the original.
REQ-035 reset=0 mid-run (RUN and PAUSED, separately) -> next cycle out=00000000, busy=0, done=0; assertions check done is one cycle wide and phase==decode(out) every cycle.
